// File: rtl/cnt_capture_fifo.sv
// cnt_capture_fifo: snapshots {epoch, cnt_in} on each rising edge of cap_trig
// into a small FIFO. Epoch counts wrap_in pulses from the upstream counter.
// Optional macro CAP_SYNC_EN: pass cap_trig through a two-flop synchronizer
// before edge detection (capture lands on the 3rd edge instead of the 1st).
module cnt_capture_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    cnt_in,
    input  logic          wrap_in,
    input  logic          cap_trig,
    input  logic          clr,
    output logic [15:0]   dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic          cap_s;
    logic          cap_d;
    logic [1:0]    arm_cnt;
    logic          armed;
    logic          cap_ev;
    logic [7:0]    epoch;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          full;
    logic          push;
    logic          pop;
    logic [15:0]   mem [DEPTH];

`ifdef CAP_SYNC_EN
    // Edge detection stays disarmed until the synchronizer has flushed the
    // trigger level present at reset release, so a held trigger is ignored.
    localparam logic [1:0] ARM = 2'd3;

    logic sync1;
    logic sync2;

    // Two-flop synchronizer for the possibly asynchronous capture request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= cap_trig;
            sync2 <= sync1;
        end
    end

    assign cap_s = sync2;
`else
    localparam logic [1:0] ARM = 2'd1;

    assign cap_s = cap_trig;
`endif

    // Delayed copy of cap_s for edge detection; clr does not touch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_d <= 1'b0;
        end else begin
            cap_d <= cap_s;
        end
    end

    // Count edges since reset release until edge detection is armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= '0;
        end else if (arm_cnt != ARM) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed  = (arm_cnt == ARM);
    assign cap_ev = armed & cap_s & ~cap_d;

    assign level     = wptr - rptr;
    assign full      = (level == FULL_LVL);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready & ~clr;
    // A full FIFO still accepts a capture when the head leaves on the same edge
    assign push      = cap_ev & (~full | pop) & ~clr;

    // Epoch counter: advances on wrap_in, flushed by clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch <= '0;
        end else if (clr) begin
            epoch <= '0;
        end else if (wrap_in) begin
            epoch <= epoch + 8'd1;
        end
    end

    // Read/write pointers, one extra bit so full and empty are distinct
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Sticky drop flag: capture arrived while full and nothing left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (cap_ev && full && !pop) begin
            ovf <= 1'b1;
        end
    end

    // Storage write; epoch here is the value before any same-edge wrap_in
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= {epoch, cnt_in};
        end
    end

    // Head entry is forced to zero whenever the FIFO is empty
    always_comb begin
        dout = '0;
        if (out_valid) begin
            dout = mem[rptr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_cnt_capture_fifo.sv
// Self-checking bench for cnt_capture_fifo with a queue-based scoreboard.
// Works with or without CAP_SYNC_EN defined.
module tb_cnt_capture_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef CAP_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic [7:0]    cnt_in;
    logic          wrap_in;
    logic          cap_trig;
    logic          clr;
    logic [15:0]   dout;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          ovf;

    int            total = 0;
    int            bad   = 0;

    logic [15:0]   q[$];
    logic [7:0]    m_epoch;
    logic          m_ovf;
    logic [3:0]    hist;
    int            edges;
    int            lat_seen;

    cnt_capture_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_in    (cnt_in),
        .wrap_in   (wrap_in),
        .cap_trig  (cap_trig),
        .clr       (clr),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_epoch = '0;
        m_ovf   = 1'b0;
        hist    = '0;
        edges   = 0;
    endtask

    // One clock: drive inputs at negedge, check outputs, predict the edge
    task automatic step(input logic wr, input logic tr, input logic rdy,
                        input logic [7:0] c, input logic cl);
        logic        pop;
        logic        ev;
        logic        full;
        logic [15:0] ent;
        wrap_in   = wr;
        cap_trig  = tr;
        out_ready = rdy;
        cnt_in    = c;
        clr       = cl;
        check("valid", 32'(out_valid), 32'(q.size() != 0));
        check("level", 32'(level), 32'(q.size()));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (q.size() != 0) check("head", 32'(dout), 32'(q[0]));
        pop  = (q.size() != 0) && rdy && !cl;
        hist = {hist[2:0], tr};
        ev   = (edges >= LAT) && hist[LAT-1] && !hist[LAT];
        if (edges < LAT) edges++;
        full = (q.size() == DEPTH);
        ent  = {m_epoch, c};
        @(posedge clk);
        if (cl) begin
            q.delete();
            m_epoch = '0;
            m_ovf   = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (ev) begin
                if (full && !pop) m_ovf = 1'b1;
                else q.push_back(ent);
            end
            if (wr) m_epoch = m_epoch + 8'd1;
        end
        @(negedge clk);
    endtask

    task automatic cap(input logic [7:0] c, input logic rdy);
        step(1'b0, 1'b1, rdy, c, 1'b0);
        step(1'b0, 1'b0, rdy, c, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && level == '0) break;
            step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        end
        check("drained", 32'(level), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cnt_in    = '0;
        wrap_in   = 1'b0;
        cap_trig  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_dout", 32'(dout), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Single capture at cnt 2A, epoch 0
        for (int i = 0; i <= LAT; i++) step(1'b0, i == 0, 1'b0, 8'h2A, 1'b0);
        check("first_dout", 32'(dout), 32'h002A);
        check("first_level", 32'(level), 32'd1);
        check("first_valid", 32'(out_valid), 32'd1);
        drain();

        // Three wraps, capture at 10, then capture coincident with wrap at FF
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i <= LAT; i++) step(1'b0, i == 0, 1'b0, 8'h10, 1'b0);
        check("epoch3_dout", 32'(dout), 32'h0310);
        for (int i = 0; i <= LAT; i++) step(i == LAT - 1, i == 0, 1'b0, 8'hFF, 1'b0);
        check("coinc_level", 32'(level), 32'd2);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("coinc_dout", 32'(dout), 32'h03FF);
        drain();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Nine captures into a DEPTH-8 FIFO with no consumer
        for (int i = 0; i < 9; i++) cap(8'(8'h50 + i), 1'b0);
        idle(LAT);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_set", 32'(ovf), 32'd1);
        drain();
        check("ovf_sticky", 32'(ovf), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("ovf_clr", 32'(ovf), 32'd0);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) cap(8'(8'h80 + i), 1'b0);
        idle(LAT);
        check("full_level", 32'(level), 32'd8);
        for (int i = 0; i <= LAT; i++) step(1'b0, i == 0, i == LAT - 1, 8'hC3, 1'b0);
        check("pp_level", 32'(level), 32'd8);
        check("pp_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("pp_tail", 32'(dout), 32'h00C3);
        drain();

        // Held trigger: one capture, measured latency
        idle(LAT + 1);
        lat_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
            if (lat_seen == 0 && level != '0) lat_seen = i;
        end
        check("latency", 32'(lat_seen), 32'(LAT));
        check("held_level", 32'(level), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(1) == 0,
                 8'($urandom), $urandom_range(60) == 0);
        idle(LAT + 1);
        drain();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset with five entries in flight
        for (int i = 0; i < 5; i++) cap(8'(8'hA0 + i), 1'b0);
        idle(LAT);
        check("pre_rst_level", 32'(level), 32'd5);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        #1;
        cap_trig = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_dout", 32'(dout), 32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // Trigger already high at release must not capture
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
        check("held_rst_level", 32'(level), 32'd0);
        idle(LAT + 1);
        for (int i = 0; i <= LAT; i++) step(1'b0, i == 0, 1'b0, 8'h44, 1'b0);
        check("post_rst_dout", 32'(dout), 32'h0044);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnt_capture_fifo.md
CNT_CAPTURE_FIFO -- requirements
Module: cnt_capture_fifo

Interface
REQ-001 Parameter: DEPTH, 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter: AW, 3, FIFO address width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  in  1  clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: cnt_in  in  8  free-running count from the upstream 8-bit counter.
REQ-006 Port: wrap_in  in  1  one-cycle pulse from the upstream counter marking a count period end.
REQ-007 Port: cap_trig  in  1  external capture request, level, possibly asynchronous to clk.
REQ-008 Port: clr  in  1  synchronous flush of FIFO, epoch and overflow flag.
REQ-009 Port: dout  out  16  head entry {epoch[7:0], count[7:0]}.
REQ-010 Port: out_valid  out  1  dout holds a valid entry.
REQ-011 Port: out_ready  in  1  consumer accepts dout.
REQ-012 Port: level  out  AW+1  current FIFO occupancy, 0..DEPTH.
REQ-013 Port: ovf  out  1  sticky flag: a capture was dropped.

Function
REQ-014 epoch[7:0] SHALL increment on every clk edge with wrap_in=1; 255 wraps to 0.
REQ-015 Rising-edge detection: cap_s is the (optionally synchronized) cap_trig; cap_d is cap_s delayed one clk; a capture event SHALL occur on the edge where cap_s=1 and cap_d=0.
REQ-016 On a capture event, {epoch, cnt_in} as present at that edge SHALL be written to the FIFO tail.
REQ-017 Capture and wrap_in on the same edge: the stored epoch SHALL be the pre-increment value.
REQ-018 A held-high cap_trig SHALL produce exactly one capture event.
REQ-019 Pop SHALL occur on any edge where out_valid=1 and out_ready=1; dout then advances to the next entry.
REQ-020 out_valid SHALL equal (level!=0); dout SHALL be registered or RAM-read so a write into an empty FIFO shows out_valid=1 on the following cycle.
REQ-021 dout SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Full (level=DEPTH) with no pop on that edge: capture SHALL be dropped and ovf set to 1.
REQ-023 Full with a pop on the same edge: both push and pop SHALL occur, level unchanged, no drop.
REQ-024 Empty with a push on the same edge: no pop SHALL occur (out_valid=0 that cycle); level becomes 1.
REQ-025 Read/write pointers SHALL be AW+1 bits and wrap modulo 2*DEPTH; full/empty are derived from them.
REQ-026 ovf SHALL remain 1 until clr or reset.
REQ-027 clr=1 SHALL, on that edge, empty the FIFO, zero epoch and ovf, and suppress any simultaneous push or pop; cap_d still updates.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear pointers, epoch, cap_d, synchronizer flops, ovf; outputs: out_valid=0, level=0, ovf=0, dout=16'h0000.
REQ-029 Reset mid-operation SHALL discard all stored entries; no capture is recorded for a cap_trig already high at reset release.

Configuration
REQ-030 Macro CAP_SYNC_EN defined: cap_s SHALL be cap_trig through a two-flop synchronizer; capture fires on the 3rd clk edge after cap_trig is first sampled high.
REQ-031 Macro CAP_SYNC_EN undefined: cap_s SHALL be cap_trig directly (caller guarantees clk-synchronous); capture fires on the 1st edge cap_trig is sampled high.

Verification
REQ-032 Reset, hold out_ready=0, pulse cap_trig while cnt_in=8'h2A, epoch=0 -> one entry dout=16'h002A, level=1, out_valid=1.
REQ-033 Three wrap_in pulses then capture at cnt_in=8'h10 -> dout=16'h0310; wrap_in coincident with capture at cnt_in=8'hFF -> stored epoch pre-increment.
REQ-034 out_ready=0, nine captures with DEPTH=8 -> level=8, ninth dropped, ovf=1; drain 8 entries in order, ovf still 1 until clr.
REQ-035 Full FIFO, out_ready=1 and capture on the same edge -> level stays 8, ovf stays 0, new entry at tail.
REQ-036 cap_trig held high 20 cycles -> exactly one entry; with and without CAP_SYNC_EN, capture latency 3 vs 1 edges.
REQ-037 Assert rst_n=0 with level=5 mid-transfer -> out_valid=0, level=0, ovf=0 immediately, before the next clk edge.
